sm3_compress: RTL and testbench

Iterative SM3 compression engine: accepts one padded 512-bit message block per handshake, expands it with the existing combinational `msg_expand` block, runs the 64 SM3 rounds at one round per clock, and updates the 256-bit chaining value V. It is the consumer of `msg_expand` outputs and sits between the message padder upstream and the digest consumer downstream.

---
 rtl/sm3_pkg.sv | 35 +++
 rtl/msg_expand.sv | 35 +++
 rtl/sm3_round.sv | 28 ++
 rtl/sm3_compress.sv | 95 +++++++++
 tb/tb_sm3_compress.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sm3_pkg.sv
// Shared SM3 constants, FSM state type and round helper functions.
package sm3_pkg;

  localparam logic [255:0] SM3_IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [31:0]  T_LO   = 32'h79cc4519;
  localparam logic [31:0]  T_HI   = 32'h7a879d8a;
  localparam int           ROUNDS = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
  endfunction

  // hi selects the majority form used from round 16 onward
  function automatic logic [31:0] ff_j(input logic hi, input logic [31:0] x,
                                       input logic [31:0] y, input logic [31:0] z);
    return hi ? ((x & y) | (x & z) | (y & z)) : (x ^ y ^ z);
  endfunction

  function automatic logic [31:0] gg_j(input logic hi, input logic [31:0] x,
                                       input logic [31:0] y, input logic [31:0] z);
    return hi ? ((x & y) | (~x & z)) : (x ^ y ^ z);
  endfunction

endpackage

// File: rtl/msg_expand.sv
// SM3 message expansion: W_0..W_63 on msg_o, W'_0..W'_63 on msg0_o (word j at [32*j +: 32]).
module msg_expand (
  input  logic [511:0]  block_i,
  output logic [2047:0] msg_o,
  output logic [2047:0] msg0_o
);

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
  endfunction

  logic [31:0] w [68];

  always_comb begin
    for (int k = 0; k < 68; k++) w[k] = '0;
    for (int k = 0; k < 16; k++) w[k] = block_i[511 - 32*k -: 32];
    for (int k = 16; k < 68; k++) begin
      w[k] = p1(w[k-16] ^ w[k-9] ^ rotl(w[k-3], 5'd15)) ^ rotl(w[k-13], 5'd7) ^ w[k-6];
    end
  end

  always_comb begin
    msg_o  = '0;
    msg0_o = '0;
    for (int k = 0; k < 64; k++) begin
      msg_o[32*k +: 32]  = w[k];
      msg0_o[32*k +: 32] = w[k] ^ w[k+4];
    end
  end

endmodule

// File: rtl/sm3_round.sv
// One combinational SM3 round over the packed working state {A,B,C,D,E,F,G,H}.
module sm3_round
  import sm3_pkg::*;
(
  input  logic [255:0] state_i,
  input  logic [5:0]   j_i,
  input  logic [31:0]  w_i,
  input  logic [31:0]  w1_i,
  output logic [255:0] state_o
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t_j, a12, ss1, ss2, tt1, tt2;
  logic        hi;

  assign {a, b, c, d, e, f, g, h} = state_i;

  assign hi  = (j_i >= 6'd16);
  assign t_j = hi ? T_HI : T_LO;
  assign a12 = rotl32(a, 5'd12);
  assign ss1 = rotl32(a12 + e + rotl32(t_j, j_i[4:0]), 5'd7);
  assign ss2 = ss1 ^ a12;
  assign tt1 = ff_j(hi, a, b, c) + d + ss2 + w1_i;
  assign tt2 = gg_j(hi, e, f, g) + h + ss1 + w_i;

  assign state_o = {tt1, a, rotl32(b, 5'd9), c, p0(tt2), e, rotl32(f, 5'd19), g};

endmodule

// File: rtl/sm3_compress.sv
// Iterative SM3 compression: one 512-bit block per handshake, one round per clock.
//
// state   | meaning
// IDLE    | no block processed since reset, ready for a block
// RUN     | rounds 0..63 in progress, inputs ignored
// DONE    | digest valid in V, ready for the next block
module sm3_compress
  import sm3_pkg::*;
#(
  parameter logic [255:0] IV = SM3_IV
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_data,
  input  logic         in_first,
  output logic         out_valid,
  output logic [255:0] out_digest
);

  state_e       state_q;
  logic [5:0]   j_q;
  logic [511:0] blk_q;
  logic [255:0] work_q;
  logic [255:0] v_q;
  logic         first_q;
  logic         out_valid_q;

  logic [2047:0] msg, msg0;
  logic [31:0]   w_j, w1_j;
  logic [255:0]  work_d;
  logic [255:0]  chain_base;

  msg_expand u_msg_expand (
    .block_i (blk_q),
    .msg_o   (msg),
    .msg0_o  (msg0)
  );

  assign w_j  = msg[{j_q, 5'd0} +: 32];
  assign w1_j = msg0[{j_q, 5'd0} +: 32];

  sm3_round u_round (
    .state_i (work_q),
    .j_i     (j_q),
    .w_i     (w_j),
    .w1_i    (w1_j),
    .state_o (work_d)
  );

  // A first block chains from IV at the final XOR, so V keeps showing the old digest during RUN
  assign chain_base = first_q ? IV : v_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      j_q         <= '0;
      blk_q       <= '0;
      work_q      <= IV;
      v_q         <= IV;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (in_valid) begin
            blk_q       <= in_data;
            work_q      <= in_first ? IV : v_q;
            first_q     <= in_first;
            j_q         <= '0;
            out_valid_q <= 1'b0;
            state_q     <= ST_RUN;
          end
        end
        ST_RUN: begin
          work_q <= work_d;
          j_q    <= j_q + 6'd1;
          if (j_q == 6'(ROUNDS - 1)) begin
            v_q         <= chain_base ^ work_d;
            first_q     <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q != ST_RUN);
  assign out_valid  = out_valid_q;
  assign out_digest = v_q;

endmodule

// File: tb/tb_sm3_compress.sv
// Self-checking bench for sm3_compress: cycle-level reference model plus known-answer digests.
module tb_sm3_compress;

  localparam logic [255:0] IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_ABCD1 = {16{32'h61626364}};
  localparam logic [511:0] BLK_ABCD2 = {32'h80000000, 448'h0, 32'h00000200};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DG_ABC =
    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [255:0] DG_ABCD =
    256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
  localparam logic [255:0] DG_EMPTY =
    256'h1ab21d83_55cfa17f_8e611948_31e81a8f_22bec8c7_28fefb74_7ed035eb_5082aa2b;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_first = 1'b0;
  logic [511:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [255:0] out_digest;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sm3_compress dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_first   (in_first),
    .out_valid  (out_valid),
    .out_digest (out_digest)
  );

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    int s;
    s = n % 32;
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  // Straight textbook SM3 compression function CF(V, B)
  function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] b);
    logic [31:0] w [68];
    logic [31:0] r [8];
    logic [31:0] x, t, ss1, ss2, ff, gg, tt1, tt2;
    for (int j = 0; j < 16; j++) w[j] = b[511 - 32*j -: 32];
    for (int j = 16; j < 68; j++) begin
      x = w[j-16] ^ w[j-9] ^ rl(w[j-3], 15);
      w[j] = x ^ rl(x, 15) ^ rl(x, 23) ^ rl(w[j-13], 7) ^ w[j-6];
    end
    for (int i = 0; i < 8; i++) r[i] = v[255 - 32*i -: 32];
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rl(rl(r[0], 12) + r[4] + rl(t, j), 7);
      ss2 = ss1 ^ rl(r[0], 12);
      ff  = (j < 16) ? (r[0] ^ r[1] ^ r[2]) : ((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]));
      gg  = (j < 16) ? (r[4] ^ r[5] ^ r[6]) : ((r[4] & r[5]) | (~r[4] & r[6]));
      tt1 = ff + r[3] + ss2 + (w[j] ^ w[j+4]);
      tt2 = gg + r[7] + ss1 + w[j];
      r[3] = r[2]; r[2] = rl(r[1], 9); r[1] = r[0]; r[0] = tt1;
      r[7] = r[6]; r[6] = rl(r[5], 19); r[5] = r[4];
      r[4] = tt2 ^ rl(tt2, 9) ^ rl(tt2, 17);
    end
    return v ^ {r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7]};
  endfunction

  // Cycle-level model: busy countdown of 64 edges after each accepted block
  int           m_cnt = 0;
  logic         m_valid = 1'b0;
  logic [255:0] m_v = IV;
  logic [255:0] m_pend = '0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt   <= 0;
      m_valid <= 1'b0;
      m_v     <= IV;
      chk_en  <= 1'b1;
    end else if (m_cnt == 0 && in_valid) begin
      m_pend  <= sm3_cf(in_first ? IV : m_v, in_data);
      m_cnt   <= 64;
      m_valid <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_v     <= m_pend;
        m_valid <= 1'b1;
      end
    end
  end

  task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_int("in_ready", int'(in_ready), (m_cnt == 0) ? 1 : 0);
      check_int("out_valid", int'(out_valid), int'(m_valid));
      check256("out_digest", out_digest, m_v);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [511:0] d, input logic f);
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      errors++;
      checks++;
      $display("FAIL wait_valid: out_valid not seen within %0d cycles", n);
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_int("reset_ready", int'(in_ready), 1);
    check_int("reset_valid", int'(out_valid), 0);
    check256("reset_digest", out_digest, IV);

    // Pin the reference model to the published digests
    check256("model_abc", sm3_cf(IV, BLK_ABC), DG_ABC);
    check256("model_abcd", sm3_cf(sm3_cf(IV, BLK_ABCD1), BLK_ABCD2), DG_ABCD);
    check256("model_empty", sm3_cf(IV, BLK_EMPTY), DG_EMPTY);

    send(BLK_ABC, 1'b1);
    wait_valid(n);
    check_int("abc_latency", n, 64);
    check256("abc_digest", out_digest, DG_ABC);

    send(BLK_ABCD1, 1'b1);
    wait_valid(n);
    send(BLK_ABCD2, 1'b0);
    check_int("abcd_valid_low", int'(out_valid), 0);
    wait_valid(n);
    check_int("abcd_latency", n, 64);
    check256("abcd_digest", out_digest, DG_ABCD);

    send(BLK_EMPTY, 1'b1);
    wait_valid(n);
    check256("empty_digest", out_digest, DG_EMPTY);

    // Garbage on the inputs while busy must be ignored
    send(BLK_ABC, 1'b1);
    for (int i = 0; i < 63; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_first = 1'($urandom_range(0, 1));
      in_data  = rand_block();
      tick();
    end
    in_valid = 1'b0;
    tick();
    check_int("toggle_valid", int'(out_valid), 1);
    check256("toggle_digest", out_digest, DG_ABC);

    send(BLK_ABC, 1'b1);
    repeat (30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_int("midrun_rst_valid", int'(out_valid), 0);
    check_int("midrun_rst_ready", int'(in_ready), 1);
    check256("midrun_rst_digest", out_digest, IV);
    send(BLK_ABC, 1'b1);
    wait_valid(n);
    check256("after_rst_digest", out_digest, DG_ABC);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(BLK_ABC, 1'b0);
    wait_valid(n);
    check256("abc_nofirst_digest", out_digest, DG_ABC);

    // Random traffic, including back-to-back accepts and chained blocks
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_first = 1'($urandom_range(0, 1));
      in_data  = rand_block();
      tick();
    end
    in_valid = 1'b0;
    repeat (70) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
